// File: rtl/ahb_lite_sram_slave_if.sv
// AHB-Lite bus bundle between a master (or interconnect mux) and the SRAM slave.
// Handshake: an address phase is taken on a rising edge where hsel & htrans[1] & hready are all 1;
// its data phase completes on the first later edge with hreadyout = 1, and hresp qualifies that completion.
interface ahb_lite_sram_slave_if;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [3:0]  hprot;
  logic [31:0] hwdata;
  logic        hready;
  logic        hreadyout;
  logic        hresp;
  logic [31:0] hrdata;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hprot, hwdata, hready,
    input  hreadyout, hresp, hrdata
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hprot, hwdata, hready,
    output hreadyout, hresp, hrdata
  );
endinterface

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite SRAM slave: programmable wait states, byte/half/word writes, full-word reads,
// and a two-cycle ERROR response for misaligned, out-of-region or read-only-write accesses.
module ahb_lite_sram_slave #(
    parameter int          ADDR_WIDTH  = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 1,
    parameter int          RO_WORDS    = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    ahb_lite_sram_slave_if.slave       bus,
    output logic [2:0]                 dbg_state
);
    localparam int          IW       = ADDR_WIDTH - 2;
    localparam int          DEPTH    = 1 << IW;
    localparam logic [31:0] RO_LIMIT = 32'(RO_WORDS);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_DATA = 3'd2,
        S_ERR1 = 3'd3,
        S_ERR2 = 3'd4
    } state_t;

    state_t        state, state_nx;
    logic [3:0]    cnt, cnt_nx;
    logic [IW-1:0] idx_q;
    logic [1:0]    lane_q;
    logic [1:0]    size_q;
    logic          write_q;
    logic [31:0]   mem [DEPTH];

    logic          open_phase, accept, illegal, ro_hit, region_ok;
    logic [IW-1:0] idx_in;
    logic [32:0]   ro_diff;
    logic [3:0]    be;
    logic          readyout, resp;
    logic          unused_bits;

    assign unused_bits = ^{bus.hprot, bus.htrans[0]};

    // New address phases are only taken while this slave is itself showing hreadyout = 1.
    assign open_phase = (state == S_IDLE) || (state == S_DATA) || (state == S_ERR2);
    assign accept     = open_phase && bus.hsel && bus.htrans[1] && bus.hready;

    assign idx_in    = bus.haddr[ADDR_WIDTH-1:2];
    // Borrow out of (index - RO_WORDS) flags a read-only word without a constant compare.
    assign ro_diff   = {1'b0, 32'(idx_in)} - {1'b0, RO_LIMIT};
    assign ro_hit    = ro_diff[32];
    assign region_ok = (bus.haddr[31:ADDR_WIDTH] == BASE_ADDR[31:ADDR_WIDTH]);
    assign illegal   = (bus.hsize > 3'd2)
                     || ((bus.hsize == 3'd1) && bus.haddr[0])
                     || ((bus.hsize == 3'd2) && (bus.haddr[1:0] != 2'b00))
                     || !region_ok
                     || (bus.hwrite && ro_hit);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        readyout = 1'b1;
        resp     = 1'b0;
        case (state)
            S_IDLE, S_DATA, S_ERR2: begin
                resp = (state == S_ERR2);
                if (accept) begin
                    if (illegal) begin
                        state_nx = S_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_nx = S_WAIT;
                        cnt_nx   = 4'(WAIT_STATES);
                    end else begin
                        state_nx = S_DATA;
                    end
                end else begin
                    state_nx = S_IDLE;
                end
            end
            S_WAIT: begin
                readyout = 1'b0;
                cnt_nx   = cnt - 4'd1;
                if (cnt <= 4'd1) state_nx = S_DATA;
            end
            S_ERR1: begin
                readyout = 1'b0;
                resp     = 1'b1;
                state_nx = S_ERR2;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            idx_q   <= '0;
            lane_q  <= 2'd0;
            size_q  <= 2'd0;
            write_q <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (accept) begin
                idx_q   <= idx_in;
                lane_q  <= bus.haddr[1:0];
                size_q  <= bus.hsize[1:0];
                write_q <= bus.hwrite;
            end
        end
    end

    always_comb begin
        be = 4'b1111;
        case (size_q)
            2'd0:    be = 4'b0001 << lane_q;
            2'd1:    be = lane_q[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
    end

    // Reset forces state to IDLE asynchronously, so an aborted write never reaches this edge.
    always_ff @(posedge clk) begin
        if ((state == S_DATA) && write_q) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx_q][8*b +: 8] <= bus.hwdata[8*b +: 8];
            end
        end
    end

    assign bus.hreadyout = readyout;
    assign bus.hresp     = resp;
    assign bus.hrdata    = ((state == S_DATA) && !write_q) ? mem[idx_q] : 32'h0;
    assign dbg_state     = state;
endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Directed per-cycle vectors against two slave builds: WAIT_STATES=1/RO_WORDS=4 and WAIT_STATES=0/RO_WORDS=0.
module tb_ahb_lite_sram_slave;
  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NS = 2'b10;
  localparam logic [2:0] SZ_B = 3'd0, SZ_H = 3'd1, SZ_W = 3'd2, SZ_BAD = 3'd3;

  typedef struct {
    logic        w0;
    logic        hsel;
    logic [1:0]  htrans;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic        e_rdy;
    logic        e_resp;
    logic [31:0] e_rdata;
    logic        chk_rd;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [2:0] dbg1, dbg0;
  int n_applied = 0;
  int n_miss = 0;
  vec_t vecs[$];

  ahb_lite_sram_slave_if bus1 ();
  ahb_lite_sram_slave_if bus0 ();
  assign bus1.hready = bus1.hreadyout;
  assign bus0.hready = bus0.hreadyout;

  ahb_lite_sram_slave #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0), .WAIT_STATES(1), .RO_WORDS(4)) dut_w1 (
    .clk(clk), .reset(reset), .bus(bus1), .dbg_state(dbg1));
  ahb_lite_sram_slave #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0), .WAIT_STATES(0), .RO_WORDS(0)) dut_w0 (
    .clk(clk), .reset(reset), .bus(bus0), .dbg_state(dbg0));

  always #5 clk = ~clk;

  function automatic vec_t mk(logic w0, logic hsel, logic [1:0] tr, logic [31:0] a, logic wr,
                              logic [2:0] sz, logic [31:0] wd, logic er, logic ep,
                              logic [31:0] ed, logic cr);
    vec_t v;
    v.w0 = w0; v.hsel = hsel; v.htrans = tr; v.haddr = a; v.hwrite = wr; v.hsize = sz;
    v.hwdata = wd; v.e_rdy = er; v.e_resp = ep; v.e_rdata = ed; v.chk_rd = cr;
    return v;
  endfunction

  function automatic vec_t ap(logic w0, logic [31:0] a, logic wr, logic [2:0] sz, logic [31:0] wd,
                              logic er, logic ep, logic [31:0] ed);
    return mk(w0, 1'b1, T_NS, a, wr, sz, wd, er, ep, ed, 1'b1);
  endfunction

  function automatic vec_t idl(logic w0, logic [31:0] wd, logic er, logic ep, logic [31:0] ed);
    return mk(w0, 1'b0, T_IDLE, 32'h0, 1'b0, SZ_W, wd, er, ep, ed, 1'b1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus1.hsel = v.w0 ? 1'b0 : v.hsel;
    bus1.htrans = v.w0 ? T_IDLE : v.htrans;
    bus0.hsel = v.w0 ? v.hsel : 1'b0;
    bus0.htrans = v.w0 ? v.htrans : T_IDLE;
    bus1.haddr = v.haddr;   bus0.haddr = v.haddr;
    bus1.hwrite = v.hwrite; bus0.hwrite = v.hwrite;
    bus1.hsize = v.hsize;   bus0.hsize = v.hsize;
    bus1.hwdata = v.hwdata; bus0.hwdata = v.hwdata;
    bus1.hprot = 4'b0011;   bus0.hprot = 4'b0011;
  endtask

  task automatic compare(input vec_t v, input string tag);
    logic rdy, rsp;
    logic [31:0] rd;
    rdy = v.w0 ? bus0.hreadyout : bus1.hreadyout;
    rsp = v.w0 ? bus0.hresp : bus1.hresp;
    rd  = v.w0 ? bus0.hrdata : bus1.hrdata;
    check({tag, " hreadyout"}, {31'b0, rdy}, {31'b0, v.e_rdy});
    check({tag, " hresp"}, {31'b0, rsp}, {31'b0, v.e_resp});
    if (v.chk_rd) check({tag, " hrdata"}, rd, v.e_rdata);
  endtask

  // One bus cycle: inputs change just after the rising edge, outputs are sampled mid-cycle.
  task automatic apply(input vec_t v, input string tag);
    @(posedge clk);
    #1;
    drive(v);
    @(negedge clk);
    compare(v, tag);
  endtask

  initial begin
    drive(idl(1'b0, 32'h0, 1'b1, 1'b0, 32'h0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset w1 hreadyout", {31'b0, bus1.hreadyout}, 32'd1);
    check("reset w1 hresp", {31'b0, bus1.hresp}, 32'd0);
    check("reset w1 hrdata", bus1.hrdata, 32'h0);
    check("reset w0 hreadyout", {31'b0, bus0.hreadyout}, 32'd1);
    check("reset w0 hrdata", bus0.hrdata, 32'h0);
    reset = 1'b0;

    // WAIT_STATES=1: word write then read of 0x20.
    vecs.push_back(ap (1'b0, 32'h20, 1'b1, SZ_W, 32'h0, 1'b1, 1'b0, 32'h0));
    vecs.push_back(idl(1'b0, 32'h1234_5678, 1'b0, 1'b0, 32'h0));
    vecs.push_back(ap (1'b0, 32'h20, 1'b0, SZ_W, 32'h1234_5678, 1'b1, 1'b0, 32'h0));
    vecs.push_back(idl(1'b0, 32'h0, 1'b0, 1'b0, 32'h0));
    vecs.push_back(idl(1'b0, 32'h0, 1'b1, 1'b0, 32'h1234_5678));
    vecs.push_back(idl(1'b0, 32'h0, 1'b1, 1'b0, 32'h0));
    // Partial writes into word 0x30.
    vecs.push_back(ap (1'b0, 32'h30, 1'b1, SZ_W, 32'h0, 1'b1, 1'b0, 32'h0));
    vecs.push_back(idl(1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0));
    vecs.push_back(ap (1'b0, 32'h31, 1'b1, SZ_B, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0));
    vecs.push_back(idl(1'b0, 32'h1111_0011, 1'b0, 1'b0, 32'h0));
    vecs.push_back(ap (1'b0, 32'h32, 1'b1, SZ_H, 32'h1111_0011, 1'b1, 1'b0, 32'h0));
    vecs.push_back(idl(1'b0, 32'hABCD_2222, 1'b0, 1'b0, 32'h0));
    vecs.push_back(ap (1'b0, 32'h30, 1'b0, SZ_W, 32'hABCD_2222, 1'b1, 1'b0, 32'h0));
    vecs.push_back(idl(1'b0, 32'h0, 1'b0, 1'b0, 32'h0));
    vecs.push_back(idl(1'b0, 32'h0, 1'b1, 1'b0, 32'hABCD_00FF));
    // Errors: misaligned half, hsize=3, read-only write; read-only read is OKAY.
    vecs.push_back(ap (1'b0, 32'h40, 1'b1, SZ_W, 32'h0, 1'b1, 1'b0, 32'h0));
    vecs.push_back(idl(1'b0, 32'hCAFE_0001, 1'b0, 1'b0, 32'h0));
    vecs.push_back(ap (1'b0, 32'h41, 1'b1, SZ_H, 32'hCAFE_0001, 1'b1, 1'b0, 32'h0));
    vecs.push_back(idl(1'b0, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0));
    vecs.push_back(idl(1'b0, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h0));
    vecs.push_back(ap (1'b0, 32'h44, 1'b0, SZ_BAD, 32'h0, 1'b1, 1'b0, 32'h0));
    vecs.push_back(idl(1'b0, 32'h0, 1'b0, 1'b1, 32'h0));
    vecs.push_back(ap (1'b0, 32'h08, 1'b1, SZ_W, 32'h0, 1'b1, 1'b1, 32'h0));
    vecs.push_back(idl(1'b0, 32'h5555_5555, 1'b0, 1'b1, 32'h0));
    vecs.push_back(ap (1'b0, 32'h08, 1'b0, SZ_W, 32'h5555_5555, 1'b1, 1'b1, 32'h0));
    vecs.push_back(idl(1'b0, 32'h0, 1'b0, 1'b0, 32'h0));
    vecs.push_back(mk (1'b0, 1'b1, T_NS, 32'h40, 1'b0, SZ_W, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0));
    vecs.push_back(idl(1'b0, 32'h0, 1'b0, 1'b0, 32'h0));
    vecs.push_back(idl(1'b0, 32'h0, 1'b1, 1'b0, 32'hCAFE_0001));
    // BUSY and deselected NONSEQ make no access.
    vecs.push_back(mk (1'b0, 1'b1, T_BUSY, 32'h40, 1'b0, SZ_W, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1));
    vecs.push_back(mk (1'b0, 1'b0, T_NS, 32'h40, 1'b0, SZ_W, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1));
    vecs.push_back(idl(1'b0, 32'h0, 1'b1, 1'b0, 32'h0));
    // WAIT_STATES=0: pipelined back-to-back traffic and errors from a DATA/ERR2 cycle.
    vecs.push_back(ap (1'b1, 32'h40, 1'b1, SZ_W, 32'h0, 1'b1, 1'b0, 32'h0));
    vecs.push_back(ap (1'b1, 32'h40, 1'b0, SZ_W, 32'hA5A5_A5A5, 1'b1, 1'b0, 32'h0));
    vecs.push_back(ap (1'b1, 32'h43, 1'b1, SZ_B, 32'h0, 1'b1, 1'b0, 32'hA5A5_A5A5));
    vecs.push_back(ap (1'b1, 32'h40, 1'b0, SZ_W, 32'h5A00_0000, 1'b1, 1'b0, 32'h0));
    vecs.push_back(ap (1'b1, 32'h42, 1'b0, SZ_W, 32'h0, 1'b1, 1'b0, 32'h5AA5_A5A5));
    vecs.push_back(idl(1'b1, 32'h0, 1'b0, 1'b1, 32'h0));
    vecs.push_back(ap (1'b1, 32'h400, 1'b0, SZ_W, 32'h0, 1'b1, 1'b1, 32'h0));
    vecs.push_back(idl(1'b1, 32'h0, 1'b0, 1'b1, 32'h0));
    vecs.push_back(idl(1'b1, 32'h0, 1'b1, 1'b1, 32'h0));
    vecs.push_back(idl(1'b1, 32'h0, 1'b1, 1'b0, 32'h0));

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("vec%0d", i));

    // Reset in the WAIT cycle of a write aborts it; the earlier value of 0x10 survives.
    apply(ap (1'b0, 32'h10, 1'b1, SZ_W, 32'h0, 1'b1, 1'b0, 32'h0), "pre wr addr");
    apply(idl(1'b0, 32'h0000_1111, 1'b0, 1'b0, 32'h0), "pre wr wait");
    apply(ap (1'b0, 32'h10, 1'b1, SZ_W, 32'h0000_1111, 1'b1, 1'b0, 32'h0), "abort wr addr");
    apply(idl(1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0), "abort wr wait");
    #2;
    reset = 1'b1;
    #1;
    check("mid-wait reset hreadyout", {31'b0, bus1.hreadyout}, 32'd1);
    check("mid-wait reset hresp", {31'b0, bus1.hresp}, 32'd0);
    check("mid-wait reset hrdata", bus1.hrdata, 32'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    apply(ap (1'b0, 32'h10, 1'b0, SZ_W, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0), "post rst rd addr");
    apply(idl(1'b0, 32'h0, 1'b0, 1'b0, 32'h0), "post rst rd wait");
    apply(idl(1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_1111), "post rst rd data");

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
    $finish;
  end
endmodule
